// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding and the
// requester identifiers used to remember who was granted last.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    // Memory ownership for the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_P = 2'd1,
        ST_GNT_H = 2'd2
    } state_e;

    // Requester IDs: P is the processor datapath, H is the host loader.
    localparam logic REQ_P = 1'b0;
    localparam logic REQ_H = 1'b1;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter in front of the single-port data memory (1-cycle
// synchronous read). At most one transfer per cycle, round-robin between the
// processor (P) and the host loader (H), with a bounded burst lock for H.
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   p_req/p_we/p_addr/p_wdata      processor request and payload
//   p_gnt                          processor transfer accepted this cycle
//   p_rvalid/p_rdata               processor read return (cycle after transfer)
//   h_req/h_we/h_addr/h_wdata      host request and payload
//   h_lock                         host asks to keep ownership for a burst
//   h_gnt                          host transfer accepted this cycle
//   h_rvalid/h_rdata               host read return (cycle after transfer)
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and muxed payload
//   mem_rdata                      memory read data, valid cycle after read
//   busy                           arbiter is not idle
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,

    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

    state_e            state;
    logic              last;        // requester granted on the most recent transfer
    logic [CNT_W-1:0]  lock_cnt;    // consecutive locked host transfers
    logic [CNT_W-1:0]  lock_cnt_inc;
    logic              p_rvalid_q;
    logic              h_rvalid_q;

    // Grants only require the owner to still be requesting; a dropped request
    // while owning the memory simply produces no transfer.
    assign p_gnt = (state == ST_GNT_P) & p_req;
    assign h_gnt = (state == ST_GNT_H) & h_req;
    assign busy  = (state != ST_IDLE);

    // Lock count including this cycle's transfer, saturating at the bound so a
    // lone locked host cannot wrap the counter and skip the forced release.
    assign lock_cnt_inc = (lock_cnt == LOCK_LIMIT) ? lock_cnt
                                                   : lock_cnt + CNT_W'(h_gnt & h_lock);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p_gnt) begin
            mem_en    = 1'b1;
            mem_we    = p_we;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
        end else if (h_gnt) begin
            mem_en    = 1'b1;
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    assign p_rvalid = p_rvalid_q;
    assign h_rvalid = h_rvalid_q;
    assign p_rdata  = p_rvalid_q ? mem_rdata : '0;
    assign h_rdata  = h_rvalid_q ? mem_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last       <= REQ_H;    // P wins the first tie
            lock_cnt   <= '0;
            p_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
        end else begin
            if (p_gnt) begin
                last <= REQ_P;
            end else if (h_gnt) begin
                last <= REQ_H;
            end

            p_rvalid_q <= p_gnt & ~p_we;
            h_rvalid_q <= h_gnt & ~h_we;

            // Count only survives while the host keeps a locked hold on GNT_H;
            // the branches below override this default in exactly those cases.
            lock_cnt <= '0;

            unique case (state)
                ST_IDLE: begin
                    if (p_req && h_req) begin
                        state <= (last == REQ_H) ? ST_GNT_P : ST_GNT_H;
                    end else if (p_req) begin
                        state <= ST_GNT_P;
                    end else if (h_req) begin
                        state <= ST_GNT_H;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_GNT_P: begin
                    state <= h_req ? ST_GNT_H : ST_IDLE;
                end

                ST_GNT_H: begin
                    if (h_lock && (lock_cnt_inc < LOCK_LIMIT)) begin
                        state    <= ST_GNT_H;
                        lock_cnt <= lock_cnt_inc;
                    end else if (p_req) begin
                        // Forced (or ordinary) release: exactly one P transfer.
                        state <= ST_GNT_P;
                    end else if (h_lock) begin
                        state    <= ST_GNT_H;
                        lock_cnt <= lock_cnt_inc;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter with a small behavioural
// single-port memory (1-cycle synchronous read) attached to the mem_* port.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        p_req, p_we;
    logic [15:0] p_addr, p_wdata;
    logic        p_gnt, p_rvalid;
    logic [15:0] p_rdata;

    logic        h_req, h_we, h_lock;
    logic [15:0] h_addr, h_wdata;
    logic        h_gnt, h_rvalid;
    logic [15:0] h_rdata;

    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy;

    // Bench-side preload port for the memory model.
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .LOCK_MAX(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .p_req    (p_req),
        .p_we     (p_we),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_gnt    (p_gnt),
        .p_rvalid (p_rvalid),
        .p_rdata  (p_rdata),
        .h_req    (h_req),
        .h_we     (h_we),
        .h_addr   (h_addr),
        .h_wdata  (h_wdata),
        .h_lock   (h_lock),
        .h_gnt    (h_gnt),
        .h_rvalid (h_rvalid),
        .h_rdata  (h_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle's drive point, just after the active edge.
    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gcount, first_cyc, last_cyc, hcnt, n;
        int  glog [32];
        logic pg, hg, p_up, found;

        reset = 1'b1;
        {p_req, p_we, h_req, h_we, h_lock} = '0;
        p_addr = '0; p_wdata = '0; h_addr = '0; h_wdata = '0;
        #2 reset = 1'b0;

        // Preload the read target while reset is held.
        next_drive();
        pre_we = 1'b1; pre_addr = 8'h10; pre_data = 16'hABCD;
        next_drive();
        pre_we = 1'b0;

        // ---------------- reset with random inputs ----------------
        for (int i = 0; i < 3; i++) begin
            p_req = 1'($urandom); p_we = 1'($urandom);
            p_addr = 16'($urandom); p_wdata = 16'($urandom);
            h_req = 1'($urandom); h_we = 1'($urandom); h_lock = 1'($urandom);
            h_addr = 16'($urandom); h_wdata = 16'($urandom);
            @(negedge clk);
            check("rst_ctl", 32'({p_gnt, p_rvalid, h_gnt, h_rvalid, mem_en, mem_we, busy}), 32'd0);
            check("rst_rdata", {p_rdata, h_rdata}, 32'd0);
            check("rst_mem", {mem_addr, mem_wdata}, 32'd0);
            next_drive();
        end
        {p_req, p_we, h_req, h_we, h_lock} = '0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_en", 32'(mem_en), 32'd0);
            next_drive();
        end

        // ---------------- single P read ----------------
        p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0010;
        @(negedge clk);                                  // cycle 0
        check("rd_c0_gnt", 32'(p_gnt), 32'd0);
        next_drive();
        @(negedge clk);                                  // cycle 1
        check("rd_c1_pgnt", 32'(p_gnt), 32'd1);
        check("rd_c1_hgnt", 32'(h_gnt), 32'd0);
        check("rd_c1_en", 32'({mem_en, mem_we}), 32'b10);
        check("rd_c1_addr", 32'(mem_addr), 32'h0010);
        next_drive();
        p_req = 1'b0;
        @(negedge clk);                                  // cycle 2
        check("rd_c2_rvalid", 32'(p_rvalid), 32'd1);
        check("rd_c2_rdata", 32'(p_rdata), 32'hABCD);
        check("rd_c2_hrvalid", 32'(h_rvalid), 32'd0);
        next_drive();
        @(negedge clk);                                  // cycle 3
        check("rd_c3_busy", 32'(busy), 32'd0);
        check("rd_c3_rvalid", 32'({p_rvalid, p_rdata}), 32'd0);
        next_drive();

        // ---------------- host locked burst ----------------
        h_req = 1'b1; h_lock = 1'b1; h_we = 1'b1; h_addr = 16'h0000; h_wdata = 16'h1111;
        gcount = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 20 && gcount < 4; cyc++) begin
            @(negedge clk);
            check("burst_no_p", 32'(p_gnt), 32'd0);
            if (h_gnt) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                gcount++;
            end
            next_drive();
            if (gcount >= 4) begin
                {h_req, h_lock, h_we} = '0;
            end else begin
                h_addr  = 16'(gcount);
                h_wdata = 16'(16'h1111 * (gcount + 1));
            end
        end
        check("burst_count", 32'(gcount), 32'd4);
        check("burst_consec", 32'(last_cyc - first_cyc), 32'd3);
        next_drive();
        next_drive();
        check("burst_mem0", 32'(mem[0]), 32'h1111);
        check("burst_mem1", 32'(mem[1]), 32'h2222);
        check("burst_mem2", 32'(mem[2]), 32'h3333);
        check("burst_mem3", 32'(mem[3]), 32'h4444);
        @(negedge clk);
        check("burst_idle", 32'(busy), 32'd0);
        next_drive();

        // ---------------- lock bound with P waiting ----------------
        for (int i = 0; i < 32; i++) glog[i] = -1;
        n = 0; hcnt = 0; p_up = 1'b0;
        h_req = 1'b1; h_lock = 1'b1; h_we = 1'b1; h_addr = 16'h0020; h_wdata = 16'h2000;
        for (int cyc = 0; cyc < 200 && hcnt < 20; cyc++) begin
            @(negedge clk);
            pg = p_gnt; hg = h_gnt;
            check("lock_excl", 32'(pg & hg), 32'd0);
            if (pg && n < 32) begin glog[n] = 0; n++; end
            if (hg && n < 32) begin glog[n] = 1; n++; hcnt++; end
            next_drive();
            if (hcnt > 0 && !p_up) begin
                p_req = 1'b1; p_we = 1'b1; p_addr = 16'h0080; p_wdata = 16'hBEEF;
                p_up = 1'b1;
            end
            if (hcnt >= 20) begin
                {h_req, h_lock, h_we, p_req, p_we} = '0;
            end else begin
                h_addr  = 16'h0020 + 16'(hcnt);
                h_wdata = 16'h2000 + 16'(hcnt);
            end
        end
        check("lock_ngrants", 32'(n), 32'd22);
        for (int i = 0; i < 22; i++) begin
            // Expected order: 8 H, 1 P, 8 H, 1 P, 4 H.
            check($sformatf("lock_seq%0d", i), 32'(glog[i]), (i == 8 || i == 17) ? 32'd0 : 32'd1);
        end
        next_drive();
        check("lock_mem_last", 32'(mem[8'h33]), 32'h2013);
        check("lock_mem_p", 32'(mem[8'h80]), 32'hBEEF);
        next_drive();

        // ---------------- reset during a host read transfer ----------------
        h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0002;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (h_gnt) found = 1'b1;
            else next_drive();
        end
        check("rr_found", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        check("rr_gnt_killed", 32'({h_gnt, mem_en, busy}), 32'd0);
        h_req = 1'b0;
        next_drive();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rr_no_rvalid", 32'({h_rvalid, h_rdata}), 32'd0);
            next_drive();
        end

        // ---------------- tie after reset: strict P,H alternation ----------------
        p_req = 1'b1; p_we = 1'b0; p_addr = 16'h0010;
        h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0002;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (p_gnt || h_gnt) found = 1'b1;
            else next_drive();
        end
        check("tie_found", 32'(found), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tie_gnt%0d", i), 32'({p_gnt, h_gnt}),
                  (i % 2 == 0) ? 32'b10 : 32'b01);
            if (i % 2 == 1) check($sformatf("tie_prdata%0d", i), 32'(p_rdata), 32'hABCD);
            if (i >= 2 && i % 2 == 0) check($sformatf("tie_hrdata%0d", i), 32'(h_rdata), 32'h3333);
            next_drive();
            @(negedge clk);
        end
        {p_req, h_req} = '0;
        next_drive();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory.
- Requester P is the processor datapath, driven by the control unit's dmem_read/dmem_write sequencing. Requester H is the host loader, which preloads and reads back image/matrix data.
- Issues at most one memory transaction per cycle. Round-robin fairness, plus a bounded lock for host bursts.
- Sits between both requesters and the data-memory macro, which has a synchronous 1-cycle read.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, data-memory address width
LOCK_MAX, 8, max consecutive locked transfers before a forced release (>=1)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
p_req  in  1  processor request; held with payload until p_gnt
p_we  in  1  1=write, 0=read
p_addr  in  ADDR_W  processor address
p_wdata  in  DATA_W  processor write data
p_gnt  out  1  transfer accepted this cycle
p_rvalid  out  1  read data valid (cycle after a read transfer)
p_rdata  out  DATA_W  read data
h_req  in  1  host request
h_we  in  1  host write enable
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_lock  in  1  host requests burst ownership
h_gnt  out  1  host transfer accepted
h_rvalid  out  1  host read data valid
h_rdata  out  DATA_W  host read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read mem_en
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last=H (so P wins the first tie), lock_cnt=0.
  - Pending rvalid flags cleared; all outputs 0.
- States:
  - IDLE: no grant.
  - GNT_P: P owns the memory this cycle.
  - GNT_H: H owns the memory this cycle.
- Grant and memory mux (combinational from registered state):
  - p_gnt = (state==GNT_P) & p_req; h_gnt = (state==GNT_H) & h_req.
  - A transfer occurs on a cycle with gnt=1.
  - mem_en = p_gnt|h_gnt. mem_we/addr/wdata are muxed from the owner; all 0 when mem_en=0.
- Next state from IDLE:
  - Both requesting: grant the requester != last.
  - Single requester: grant it.
  - Neither: stay IDLE.
- Next state from GNT_x, with other = the other requester:
  1. x=H, h_lock=1, lock_cnt<LOCK_MAX: stay GNT_H. This holds even if h_req=0; no transfer on that cycle.
  2. Else if other_req: go to GNT_other.
  3. Else if x=H and h_lock=1: stay GNT_H.
  4. Else: IDLE, even if x_req is still high.
  - Consequence: an unlocked requester alone gets at most one transfer per 2 cycles. A locked host gets one per cycle.
- lock_cnt:
  - Increments on each h_gnt while h_lock=1.
  - Clears when the state leaves GNT_H or when h_lock=0.
  - Forced release: at LOCK_MAX with p_req=1, exactly one P transfer is granted, then H regains ownership if h_lock and h_req are still high.
- last: updated to the granted requester on every transfer.
- Read return:
  - A read transfer sets x_rvalid=1 the next cycle, for one cycle.
  - p_rdata and h_rdata = mem_rdata when the matching rvalid=1, else 0.
- Write: completes in the transfer cycle; no response.
- Simultaneous read return and new grant are allowed; rvalid always belongs to the previous cycle's transfer.
- Reset asserted in a read-transfer cycle: the rvalid of that transfer is never asserted.
- Requester protocol:
  - payload must remain stable while req=1 and gnt=0.
  - A req drop without gnt is legal; no transfer occurs.

Decomposition:
- Shared package: state encoding (IDLE/GNT_P/GNT_H); requester ID constants (REQ_P=0, REQ_H=1).
- Single module. The round-robin pick is small enough to stay inline; no sub-module.

Test Plan:
- Reset: reset=0 with random inputs -> all outputs 0, busy=0. Release, no req -> stays IDLE.
- Single P read: mem[0x0010]=0xABCD, p_req/p_we=0/p_addr=0x0010 at cycle 0 -> p_gnt and mem_en at cycle 1; p_rvalid=1 with p_rdata=0xABCD at cycle 2; IDLE at cycle 3.
- Tie after reset: p_req and h_req both high continuously -> grants strictly alternate P,H,P,H starting with P; no cycle has both gnts.
- Host locked burst: h_lock=1, writes 0x1111..0x4444 to 0x0000..0x0003 -> h_gnt on 4 consecutive cycles; mem holds the values; P idle.
- Lock bound: h_lock=1 for 20 writes while p_req held -> 8 h_gnts, 1 p_gnt, then 8 h_gnts, 1 p_gnt, then the remaining 4 h_gnts.
- Reset mid-read: assert reset=0 during an h_gnt read cycle -> h_rvalid never rises; after release, the first tie goes to P.
